// File: rtl/hop_chain_seq_if.sv
// Handshake and result bundle between the hop-chain sequencer and its user.
// The slave side is the sequencer; the master side drives go/gap/chain_out.
interface hop_chain_seq_if #(
    parameter int NSTAGE = 4
);
    logic              go;
    logic [3:0]        gap;
    logic              chain_out;
    logic [NSTAGE-1:0] rst_stage;
    logic              start;
    logic              busy;
    logic              done;
    logic              pass;
    logic              err_timeout;
    logic [7:0]        latency;

    modport master (
        output go,
        output gap,
        output chain_out,
        input  rst_stage,
        input  start,
        input  busy,
        input  done,
        input  pass,
        input  err_timeout,
        input  latency
    );

    modport slave (
        input  go,
        input  gap,
        input  chain_out,
        output rst_stage,
        output start,
        output busy,
        output done,
        output pass,
        output err_timeout,
        output latency
    );
endinterface

// File: rtl/hop_chain_seq.sv
// Hop-chain reset sequencer: holds all stage resets, releases them bottom-up
// with a programmable gap, launches a pulse and measures chain latency.
module hop_chain_seq #(
    parameter int NSTAGE   = 4,
    parameter int HOLD_CYC = 2,
    parameter int TIMEOUT  = 15
) (
    input  logic           clock0,
    input  logic           rst_n,
    hop_chain_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT,
        S_RELEASE,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);
    localparam logic [7:0] TO8       = 8'(TIMEOUT);
    localparam logic [7:0] NS8       = 8'(NSTAGE);

    state_t            state_q, state_d;
    logic [NSTAGE-1:0] rst_stage_q, rst_stage_d;
    logic [NSTAGE-1:0] rst_shift;
    logic [3:0]        gap_q, gap_d;
    logic [3:0]        rel_cnt_q, rel_cnt_d;
    logic [7:0]        hold_q, hold_d;
    logic [7:0]        wait_q, wait_d;
    logic              pass_q, pass_d;
    logic              err_q, err_d;
    logic [7:0]        lat_q, lat_d;

    // Releases are thermometer-shaped, so shifting left clears the lowest set bit.
    assign rst_shift = rst_stage_q << 1;

    // State and datapath registers; reset asserts every stage reset.
    always_ff @(posedge clock0) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rst_stage_q <= '1;
            gap_q       <= '0;
            rel_cnt_q   <= '0;
            hold_q      <= '0;
            wait_q      <= '0;
            pass_q      <= 1'b0;
            err_q       <= 1'b0;
            lat_q       <= '0;
        end else begin
            state_q     <= state_d;
            rst_stage_q <= rst_stage_d;
            gap_q       <= gap_d;
            rel_cnt_q   <= rel_cnt_d;
            hold_q      <= hold_d;
            wait_q      <= wait_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            lat_q       <= lat_d;
        end
    end

    // Next-state logic; results are resolved on the WAIT->DONE edge so they
    // are already valid during the done pulse.
    always_comb begin
        state_d     = state_q;
        rst_stage_d = rst_stage_q;
        gap_d       = gap_q;
        rel_cnt_d   = rel_cnt_q;
        hold_d      = hold_q;
        wait_d      = wait_q;
        pass_d      = pass_q;
        err_d       = err_q;
        lat_d       = lat_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    state_d     = S_ASSERT;
                    gap_d       = bus.gap;
                    pass_d      = 1'b0;
                    err_d       = 1'b0;
                    lat_d       = '0;
                    rst_stage_d = '1;
                    hold_d      = '0;
                end
            end
            S_ASSERT: begin
                rst_stage_d = '1;
                if (hold_q >= HOLD_LAST) begin
                    state_d   = S_RELEASE;
                    hold_d    = '0;
                    rel_cnt_d = gap_q;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            S_RELEASE: begin
                if (rel_cnt_q == 4'd0) begin
                    rst_stage_d = rst_shift;
                    rel_cnt_d   = gap_q;
                    if (rst_shift == '0) begin
                        state_d = S_LAUNCH;
                    end
                end else begin
                    rel_cnt_d = rel_cnt_q - 4'd1;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                wait_d  = 8'd1;
            end
            S_WAIT: begin
                if (bus.chain_out) begin
                    state_d = S_DONE;
                    lat_d   = wait_q;
                    pass_d  = (wait_q == NS8);
                end else if (wait_q >= TO8) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    lat_d   = TO8;
                    pass_d  = 1'b0;
                end else if (wait_q != 8'hFF) begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                wait_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state or taken straight from registers.
    always_comb begin
        bus.rst_stage   = rst_stage_q;
        bus.start       = (state_q == S_LAUNCH);
        bus.busy        = (state_q != S_IDLE);
        bus.done        = (state_q == S_DONE);
        bus.pass        = pass_q;
        bus.err_timeout = err_q;
        bus.latency     = lat_q;
    end

endmodule

// File: tb/tb_hop_chain_seq.sv
// Directed bench for hop_chain_seq: vector table of runs plus hand-written
// reset-abort and held-go sequences, against a 4/5-stage chain model.
module tb_hop_chain_seq;

    localparam int NS = 4;
    localparam int HC = 2;
    localparam int TO = 15;

    typedef struct {
        int gap;
        int mode;
        int lat;
        int pass;
        int err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   mode = 0;
    logic [4:0] ch;
    int   n_chk = 0;
    int   n_pass = 0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    hop_chain_seq_if #(.NSTAGE(NS)) bus ();

    hop_chain_seq #(
        .NSTAGE  (NS),
        .HOLD_CYC(HC),
        .TIMEOUT (TO)
    ) dut (
        .clock0(clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Chain model: each flop is held clear by its stage reset; the optional
    // fifth flop shares the last stage reset.
    always_ff @(posedge clk) begin
        ch[0] <= bus.rst_stage[0] ? 1'b0 : bus.start;
        for (int i = 1; i < NS; i++) begin
            ch[i] <= bus.rst_stage[i] ? 1'b0 : ch[i-1];
        end
        ch[4] <= bus.rst_stage[NS-1] ? 1'b0 : ch[3];
    end

    assign bus.chain_out = (mode == 2) ? 1'b0 :
                           (mode == 1) ? ch[4] : ch[3];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic run(input int g, input int m, input int elat,
                       input int epass, input int eerr, input bit hold_go);
        int t, k, nstart, tstart, tdone, tl, bad_shape;
        logic [NS-1:0] r, prev, inv;
        bit seen;
        mode = m;
        bus.gap = 4'(g);
        bus.go = 1'b1;
        @(negedge clk);
        if (!hold_go) bus.go = 1'b0;
        tl = 3 + NS * (g + 1);
        t = 1; k = 0; nstart = 0; tstart = -1; tdone = -1;
        bad_shape = 0; seen = 0;
        prev = '1;
        check("busy_after_go", int'(bus.busy), 1);
        check("assert_all_ones", int'(bus.rst_stage), (1 << NS) - 1);
        while (t < 300 && !seen) begin
            r = bus.rst_stage;
            inv = ~r;
            if ((inv & (inv + 1'b1)) != '0) bad_shape++;
            if (r != prev) begin
                k++;
                check("release_time", t, 3 + k * (g + 1));
                prev = r;
            end
            if (bus.start) begin
                nstart++;
                tstart = t;
            end
            if (bus.done) begin
                seen = 1;
                tdone = t;
                check("latency", int'(bus.latency), elat);
                check("pass", int'(bus.pass), epass);
                check("err_timeout", int'(bus.err_timeout), eerr);
            end else begin
                @(negedge clk);
                t++;
            end
        end
        check("done_seen", int'(seen), 1);
        check("release_steps", k, NS);
        check("release_order_ok", bad_shape, 0);
        check("start_count", nstart, 1);
        check("start_time", tstart, tl);
        check("done_time", tdone, tl + elat + 1);
        @(negedge clk);
        check("idle_busy", int'(bus.busy), 0);
        check("idle_done", int'(bus.done), 0);
        check("idle_rst_stage", int'(bus.rst_stage), 0);
        check("hold_latency", int'(bus.latency), elat);
        check("hold_pass", int'(bus.pass), epass);
        check("hold_err", int'(bus.err_timeout), eerr);
    endtask

    initial begin
        bit found;
        vecs[0] = '{gap: 0,  mode: 0, lat: 4,  pass: 1, err: 0};
        vecs[1] = '{gap: 3,  mode: 0, lat: 4,  pass: 1, err: 0};
        vecs[2] = '{gap: 0,  mode: 2, lat: 15, pass: 0, err: 1};
        vecs[3] = '{gap: 0,  mode: 1, lat: 5,  pass: 0, err: 0};
        vecs[4] = '{gap: 1,  mode: 1, lat: 5,  pass: 0, err: 0};
        vecs[5] = '{gap: 15, mode: 0, lat: 4,  pass: 1, err: 0};

        bus.go = 1'b0;
        bus.gap = 4'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rst_stage", int'(bus.rst_stage), 15);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_start", int'(bus.start), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_pass", int'(bus.pass), 0);
        check("rst_err", int'(bus.err_timeout), 0);
        check("rst_latency", int'(bus.latency), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_keeps_resets", int'(bus.rst_stage), 15);
        check("idle_not_busy", int'(bus.busy), 0);

        for (int i = 0; i < 6; i++) begin
            run(vecs[i].gap, vecs[i].mode, vecs[i].lat,
                vecs[i].pass, vecs[i].err, 1'b0);
        end

        // Abort mid-release with rst_stage=1100.
        mode = 0;
        bus.gap = 4'd0;
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.rst_stage == 4'b1100) found = 1;
            else @(negedge clk);
        end
        check("abort_reached_1100", int'(found), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_rst_stage", int'(bus.rst_stage), 15);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_pass", int'(bus.pass), 0);
        check("abort_latency", int'(bus.latency), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_abort_rst_stage", int'(bus.rst_stage), 15);
        check("post_abort_done", int'(bus.done), 0);
        run(0, 0, 4, 1, 0, 1'b0);

        // go held high: one run, then re-accept clears results.
        run(0, 0, 4, 1, 0, 1'b1);
        @(negedge clk);
        check("reaccept_busy", int'(bus.busy), 1);
        check("reaccept_pass", int'(bus.pass), 0);
        check("reaccept_latency", int'(bus.latency), 0);
        check("reaccept_rst_stage", int'(bus.rst_stage), 15);
        bus.go = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus.done) found = 1;
        end
        check("reaccept_done", int'(found), 1);
        check("reaccept_result", int'(bus.pass), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hop_chain_seq.md
HOP_CHAIN_SEQ -- requirements
Module: hop_chain_seq

Interface
REQ-001 Parameter NSTAGE, default 4: number of flop stages in the controlled hop chain.
REQ-002 Parameter HOLD_CYC, default 2: cycles all stage resets are held asserted before release begins.
REQ-003 Parameter TIMEOUT, default 15: maximum WAIT cycles before timeout.
REQ-004 clock0  input  1  single clock; all logic on posedge clock0.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 go  input  1  request a sequence run; sampled in IDLE only.
REQ-007 gap  input  4  idle cycles between successive stage-reset releases; captured when go is accepted.
REQ-008 chain_out  input  1  output of the last chain stage.
REQ-009 rst_stage  output  NSTAGE  per-stage reset, active-high; bit 0 is the first stage.
REQ-010 start  output  1  one-cycle launch pulse into the chain input.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at end of run.
REQ-013 pass  output  1  run result: measured latency equals NSTAGE.
REQ-014 err_timeout  output  1  run result: chain_out not seen within TIMEOUT cycles.
REQ-015 latency  output  8  measured launch-to-output cycle count.

Function
REQ-016 The FSM SHALL have states IDLE, ASSERT, RELEASE, LAUNCH, WAIT and DONE, encoded in one state register.
REQ-017 In IDLE, go=1 SHALL be accepted: capture gap, clear pass, err_timeout and latency, and enter ASSERT next cycle; go in any other state SHALL be ignored.
REQ-018 In ASSERT, all rst_stage bits SHALL be 1 for exactly HOLD_CYC cycles, then the FSM enters RELEASE.
REQ-019 In RELEASE, a down-counter loaded with the captured gap SHALL decrement each cycle; in the cycle it reads 0, the lowest still-asserted rst_stage bit SHALL clear at the next edge and the counter reloads.
REQ-020 With gap=0, one stage SHALL release per cycle (NSTAGE RELEASE cycles); in general RELEASE lasts NSTAGE*(gap+1) cycles.
REQ-021 Release order SHALL be strictly bit 0 upward; at no time SHALL a higher bit be 0 while a lower bit is 1.
REQ-022 After the last bit clears, the FSM SHALL enter LAUNCH; start SHALL be 1 for exactly the single LAUNCH cycle, otherwise 0.
REQ-023 WAIT SHALL count cycles from 1 (first WAIT cycle) upward; the first WAIT cycle with chain_out=1 SHALL load latency with the current count and enter DONE.
REQ-024 If the count reaches TIMEOUT with chain_out still 0, err_timeout SHALL be set, latency SHALL load TIMEOUT, and the FSM SHALL enter DONE.
REQ-025 pass SHALL be set in DONE iff err_timeout=0 and latency==NSTAGE.
REQ-026 done SHALL be 1 only during the single DONE cycle; the FSM then returns to IDLE.
REQ-027 pass, err_timeout and latency SHALL hold their values from DONE until the next accepted go.
REQ-028 rst_stage SHALL remain all-0 from end of RELEASE through DONE and in IDLE after a completed run.
REQ-029 The WAIT counter SHALL saturate and never wrap; latency width 8 bits with TIMEOUT <= 255.

Reset
REQ-030 While rst_n=0 at a clock edge: state=IDLE, rst_stage all 1, start=0, busy=0, done=0, pass=0, err_timeout=0, latency=0, counters 0.
REQ-031 rst_n low in any state mid-run SHALL abort at the next edge with the values of REQ-030; no done pulse is produced.
REQ-032 After reset, rst_stage SHALL stay all 1 until a run completes RELEASE.

Verification
REQ-033 Reset, then go=1 with gap=0, 4-stage chain model -> ASSERT 2 cycles, rst_stage 1111->1110->1100->1000->0000 on consecutive cycles, start pulse, latency=4, pass=1, done pulse.
REQ-034 gap=3 -> each rst_stage bit clears 4 cycles after the previous; RELEASE lasts 16 cycles; result pass=1, latency=4.
REQ-035 chain_out tied 0 -> after 15 WAIT cycles err_timeout=1, latency=15, pass=0, done pulse.
REQ-036 chain model with one extra stage (5-cycle delay) -> latency=5, pass=0, err_timeout=0.
REQ-037 rst_n low during RELEASE with rst_stage=1100 -> next edge rst_stage=1111, busy=0, no done; a subsequent go runs cleanly to pass=1.
REQ-038 go held high through an entire run -> only one run per IDLE visit; results cleared on the re-accept cycle after DONE.
